// File: rtl/psx_xfer_if.sv
// psx_xfer_if: start/done byte handshake between the poll sequencer and the byte shift engine
interface psx_xfer_if;
    logic       xfer_start;
    logic [7:0] xfer_byte;
    logic       xfer_done;
    logic [7:0] xfer_rx;

    modport master (
        output xfer_start,
        output xfer_byte,
        input  xfer_done,
        input  xfer_rx
    );

    modport slave (
        input  xfer_start,
        input  xfer_byte,
        output xfer_done,
        output xfer_rx
    );
endinterface

// File: rtl/psx_poll_sequencer.sv
// psx_poll_sequencer: frame scheduler that polls two PSX controller ports with the 01 42 00 00 00 digital poll
module psx_poll_sequencer #(
    parameter int BOOT_TIME   = 100000,
    parameter int POLL_PERIOD = 33333,
    parameter int ATT_SETUP   = 40,
    parameter int ACK_TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          ack,
    psx_xfer_if.master    xfer,
    output logic [1:0]    att,
    output logic [15:0]   buttons0,
    output logic [15:0]   buttons1,
    output logic [1:0]    valid,
    output logic          frame_done,
    output logic          frame_port,
    output logic          err_timeout,
    output logic          err_id
);
    localparam int CMAX = BOOT_TIME > ATT_SETUP ? BOOT_TIME : ATT_SETUP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = $clog2(POLL_PERIOD + 1);
    localparam int TW   = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        BOOT, IDLE, SETUP, SEND, WAIT_DONE, WAIT_ACK, FEND, ABORT_TO, ABORT_ID, GAP
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptmr;
    logic [TW-1:0] tcnt;
    logic [2:0]  idx;
    logic        ack_seen;
    logic [7:0]  lo_byte;
    logic [2:0]  ack_s;
    logic        ack_fall;

    function automatic logic [7:0] cmd(input logic [2:0] i);
        return i == 3'd0 ? 8'h01 : i == 3'd1 ? 8'h42 : 8'h00;
    endfunction

    assign ack_fall = ack_s[2] & ~ack_s[1];

    // two-flop synchronizer for the pad ACK plus one delay stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) ack_s <= 3'b111;
        else        ack_s <= {ack_s[1:0], ack};
    end

    // frame sequencer; pulses and byte commands are registered on entry to the state that owns them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= BOOT;
            cnt             <= '0;
            ptmr            <= '0;
            tcnt            <= '0;
            idx             <= '0;
            ack_seen        <= 1'b0;
            lo_byte         <= '0;
            att             <= 2'b11;
            xfer.xfer_start <= 1'b0;
            xfer.xfer_byte  <= 8'h00;
            buttons0        <= 16'hFFFF;
            buttons1        <= 16'hFFFF;
            valid           <= 2'b00;
            frame_done      <= 1'b0;
            frame_port      <= 1'b0;
            err_timeout     <= 1'b0;
            err_id          <= 1'b0;
        end else begin
            xfer.xfer_start <= 1'b0;
            frame_done      <= 1'b0;
            err_timeout     <= 1'b0;
            err_id          <= 1'b0;
            if (ptmr != '0) ptmr <= ptmr - 1'b1;
            case (state)
                BOOT: begin
                    if (cnt == CW'(BOOT_TIME - 1)) begin
                        ptmr  <= '0;
                        state <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                IDLE: begin
                    if (enable && ptmr == '0) begin
                        att   <= frame_port ? 2'b01 : 2'b10;
                        ptmr  <= PW'(POLL_PERIOD - 1);
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(ATT_SETUP - 1)) begin
                        idx             <= '0;
                        xfer.xfer_start <= 1'b1;
                        xfer.xfer_byte  <= cmd(3'd0);
                        ack_seen        <= 1'b0;
                        state           <= SEND;
                    end else cnt <= cnt + 1'b1;
                end
                SEND: state <= WAIT_DONE;
                WAIT_DONE: begin
                    ack_seen <= ack_seen | ack_fall;
                    if (xfer.xfer_done) begin
                        if ((idx == 3'd1 && xfer.xfer_rx != 8'h41) || (idx == 3'd2 && xfer.xfer_rx != 8'h5A)) begin
                            err_id            <= 1'b1;
                            valid[frame_port] <= 1'b0;
                            state             <= ABORT_ID;
                        end else if (idx == 3'd4) begin
                            if (frame_port) buttons1 <= {xfer.xfer_rx, lo_byte};
                            else            buttons0 <= {xfer.xfer_rx, lo_byte};
                            valid[frame_port] <= 1'b1;
                            frame_done        <= 1'b1;
                            state             <= FEND;
                        end else begin
                            if (idx == 3'd3) lo_byte <= xfer.xfer_rx;
                            tcnt  <= TW'(1);
                            state <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_seen || ack_fall) begin
                        idx             <= idx + 3'd1;
                        xfer.xfer_start <= 1'b1;
                        xfer.xfer_byte  <= cmd(idx + 3'd1);
                        ack_seen        <= 1'b0;
                        state           <= SEND;
                    end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                        err_timeout       <= 1'b1;
                        valid[frame_port] <= 1'b0;
                        state             <= ABORT_TO;
                    end else tcnt <= tcnt + 1'b1;
                end
                FEND, ABORT_TO, ABORT_ID: begin
                    att   <= 2'b11;
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == CW'(ATT_SETUP - 1)) begin
                        frame_port <= ~frame_port;
                        state      <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_psx_poll_sequencer.sv
// tb_psx_poll_sequencer: directed frame scenarios against a cycle-accurate shift engine and ACK pad model
module tb_psx_poll_sequencer;
    localparam int BOOT = 100, PER = 200, SET = 4, TO = 20, DLY = 8;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ack = 1'b1;
    logic [1:0]  att, valid;
    logic [15:0] buttons0, buttons1;
    logic        frame_done, frame_port, err_timeout, err_id;

    psx_xfer_if xif();

    psx_poll_sequencer #(.BOOT_TIME(BOOT), .POLL_PERIOD(PER), .ATT_SETUP(SET), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ack(ack), .xfer(xif),
        .att(att), .buttons0(buttons0), .buttons1(buttons1), .valid(valid),
        .frame_done(frame_done), .frame_port(frame_port), .err_timeout(err_timeout), .err_id(err_id)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = -1;
    logic [7:0] rx_tbl [5];
    int ack_mode [5];
    int done_cyc [5];
    int busy = 0, ecnt = 0, b = 0, ack_dly = 0, lo_cnt = 0;
    int t_fall, n_start, n_fd, n_to, t_to, n_id, t_id, tmo;
    logic [1:0] att_low;
    logic fd_port;
    int t_start [8];
    logic [7:0] by_start [8];
    logic [7:0] exp_b [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    localparam logic [48:0] RST_VEC = {2'b11, 1'b0, 8'h00, 16'hFFFF, 16'hFFFF, 2'b00, 4'b0000};

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    // shift engine: done DLY+1 edges after start; ACK mode 1 = low 2 cycles from 3 cycles after done, 2 = early ACK before done
    initial begin
        xif.xfer_done = 1'b0;
        xif.xfer_rx = 8'h00;
        forever begin
            @(posedge clk); #1;
            xif.xfer_done = 1'b0;
            if (att == 2'b11) b = 0;
            if (lo_cnt > 0) begin lo_cnt--; if (lo_cnt == 0) ack = 1'b1; end
            if (ack_dly > 0) begin ack_dly--; if (ack_dly == 0) begin ack = 1'b0; lo_cnt = 2; end end
            if (busy != 0) begin
                ecnt--;
                if (ecnt == 3 && ack_mode[b] == 2) begin ack = 1'b0; lo_cnt = 2; end
                if (ecnt == 0) begin
                    busy = 0;
                    xif.xfer_done = 1'b1;
                    xif.xfer_rx = rx_tbl[b];
                    done_cyc[b] = cyc;
                    if (ack_mode[b] == 1) ack_dly = 3;
                    if (b < 4) b++;
                end
            end else if (xif.xfer_start === 1'b1) begin
                busy = 1;
                ecnt = DLY;
            end
        end
    end

    task automatic set_frame(input logic [39:0] r, input logic [9:0] m);
        for (int i = 0; i < 5; i++) begin
            rx_tbl[i] = r[39-8*i -: 8];
            ack_mode[i] = int'(m[9-2*i -: 2]);
        end
    endtask

    task automatic run_frame();
        int guard;
        n_start = 0; n_fd = 0; n_to = 0; n_id = 0; tmo = 0; t_to = -1; t_id = -1; t_fall = -1;
        guard = 0;
        @(negedge clk);
        while (att === 2'b11) begin
            guard++;
            if (guard > 1000) begin tmo = 1; return; end
            @(negedge clk);
        end
        t_fall = cyc;
        att_low = att;
        guard = 0;
        while (att !== 2'b11) begin
            if (xif.xfer_start === 1'b1) begin
                if (n_start < 8) begin t_start[n_start] = cyc; by_start[n_start] = xif.xfer_byte; end
                n_start++;
            end
            if (frame_done === 1'b1) begin n_fd++; fd_port = frame_port; end
            if (err_timeout === 1'b1) begin n_to++; t_to = cyc; end
            if (err_id === 1'b1) begin n_id++; t_id = cyc; end
            guard++;
            if (guard > 500) begin tmo = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({att, xif.xfer_start, xif.xfer_byte, buttons0, buttons1, valid, frame_done, frame_port, err_timeout, err_id} !== RST_VEC) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", {att, xif.xfer_start, xif.xfer_byte, buttons0, buttons1, valid, frame_done, frame_port, err_timeout, err_id}, RST_VEC); end
        set_frame(40'hFF_41_5A_FE_FF, 10'b01_01_01_01_00);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic test_boot_good_frame();
        run_frame();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL good_frame_watchdog: got %0d want 0", tmo); end
        n_cmp++; if (t_fall !== BOOT) begin n_bad++; $display("FAIL boot_att_fall_cycle: got %0d want %0d", t_fall, BOOT); end
        n_cmp++; if (att_low !== 2'b10) begin n_bad++; $display("FAIL boot_att_value: got %b want 10", att_low); end
        n_cmp++; if (t_start[0] !== BOOT + SET) begin n_bad++; $display("FAIL first_start_cycle: got %0d want %0d", t_start[0], BOOT + SET); end
        n_cmp++; if (n_start !== 5) begin n_bad++; $display("FAIL good_frame_starts: got %0d want 5", n_start); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (by_start[i] !== exp_b[i]) begin n_bad++; $display("FAIL cmd_byte%0d: got %h want %h", i, by_start[i], exp_b[i]); end
        end
        n_cmp++; if (t_start[1] !== done_cyc[0] + 6) begin n_bad++; $display("FAIL ack_advance_cycle: got %0d want %0d", t_start[1], done_cyc[0] + 6); end
        n_cmp++; if (n_fd !== 1 || fd_port !== 1'b0) begin n_bad++; $display("FAIL good_frame_done: got %0d port %b want 1 port 0", n_fd, fd_port); end
        n_cmp++; if (n_to + n_id !== 0) begin n_bad++; $display("FAIL good_frame_errors: got %0d want 0", n_to + n_id); end
        n_cmp++; if (buttons0 !== 16'hFFFE) begin n_bad++; $display("FAIL buttons0_good: got %h want FFFE", buttons0); end
        n_cmp++; if (valid !== 2'b01) begin n_bad++; $display("FAIL valid_after_port0: got %b want 01", valid); end
    endtask

    task automatic test_second_port();
        set_frame(40'hFF_41_5A_AA_55, 10'b01_01_01_01_00);
        run_frame();
        n_cmp++; if (t_fall !== BOOT + PER) begin n_bad++; $display("FAIL period_att_fall: got %0d want %0d", t_fall, BOOT + PER); end
        n_cmp++; if (att_low !== 2'b01) begin n_bad++; $display("FAIL port1_att_value: got %b want 01", att_low); end
        n_cmp++; if (n_fd !== 1 || fd_port !== 1'b1) begin n_bad++; $display("FAIL port1_frame_done: got %0d port %b want 1 port 1", n_fd, fd_port); end
        n_cmp++; if (buttons1 !== 16'h55AA) begin n_bad++; $display("FAIL buttons1_good: got %h want 55AA", buttons1); end
        n_cmp++; if (buttons0 !== 16'hFFFE) begin n_bad++; $display("FAIL buttons0_kept: got %h want FFFE", buttons0); end
        n_cmp++; if (valid !== 2'b11) begin n_bad++; $display("FAIL valid_both: got %b want 11", valid); end
    endtask

    task automatic test_timeout();
        set_frame(40'hFF_41_5A_00_00, 10'b01_01_00_01_00);
        run_frame();
        n_cmp++; if (tmo !== 0) begin n_bad++; $display("FAIL timeout_frame_watchdog: got %0d want 0", tmo); end
        n_cmp++; if (t_fall !== BOOT + 2 * PER || att_low !== 2'b10) begin n_bad++; $display("FAIL timeout_frame_start: got %0d/%b want %0d/10", t_fall, att_low, BOOT + 2 * PER); end
        n_cmp++; if (n_to !== 1) begin n_bad++; $display("FAIL timeout_pulses: got %0d want 1", n_to); end
        n_cmp++; if (t_to !== done_cyc[2] + TO) begin n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", t_to, done_cyc[2] + TO); end
        n_cmp++; if (cyc !== t_to + 1) begin n_bad++; $display("FAIL timeout_att_release: got %0d want %0d", cyc, t_to + 1); end
        n_cmp++; if (n_start !== 3 || n_fd !== 0) begin n_bad++; $display("FAIL timeout_starts_done: got %0d/%0d want 3/0", n_start, n_fd); end
        n_cmp++; if (valid !== 2'b10) begin n_bad++; $display("FAIL valid_after_timeout: got %b want 10", valid); end
        n_cmp++; if (buttons0 !== 16'hFFFE) begin n_bad++; $display("FAIL buttons0_after_timeout: got %h want FFFE", buttons0); end
    endtask

    task automatic test_bad_id();
        set_frame(40'hFF_73_5A_00_00, 10'b01_01_01_01_00);
        run_frame();
        n_cmp++; if (t_fall !== BOOT + 3 * PER || att_low !== 2'b01) begin n_bad++; $display("FAIL bad_id_frame_start: got %0d/%b want %0d/01", t_fall, att_low, BOOT + 3 * PER); end
        n_cmp++; if (n_id !== 1 || t_id !== done_cyc[1] + 1) begin n_bad++; $display("FAIL bad_id_pulse: got %0d at %0d want 1 at %0d", n_id, t_id, done_cyc[1] + 1); end
        n_cmp++; if (n_start !== 2 || n_to !== 0) begin n_bad++; $display("FAIL bad_id_starts: got %0d/%0d want 2/0", n_start, n_to); end
        n_cmp++; if (valid !== 2'b00) begin n_bad++; $display("FAIL valid_after_bad_id: got %b want 00", valid); end
        n_cmp++; if (buttons1 !== 16'h55AA) begin n_bad++; $display("FAIL buttons1_after_bad_id: got %h want 55AA", buttons1); end
    endtask

    task automatic test_early_ack();
        set_frame(40'hFF_41_5A_34_12, 10'b01_10_01_01_00);
        run_frame();
        n_cmp++; if (t_start[2] !== done_cyc[1] + 2) begin n_bad++; $display("FAIL early_ack_advance: got %0d want %0d", t_start[2], done_cyc[1] + 2); end
        n_cmp++; if (n_to !== 0 || n_fd !== 1) begin n_bad++; $display("FAIL early_ack_frame: got to=%0d done=%0d want 0/1", n_to, n_fd); end
        n_cmp++; if (buttons0 !== 16'h1234) begin n_bad++; $display("FAIL buttons0_early: got %h want 1234", buttons0); end
        n_cmp++; if (valid !== 2'b01) begin n_bad++; $display("FAIL valid_after_early: got %b want 01", valid); end
    endtask

    task automatic test_reset_mid_frame();
        int guard, t_att, t_s;
        logic [1:0] a_low;
        set_frame(40'hFF_41_5A_AA_55, 10'b01_01_01_01_00);
        guard = 0;
        n_start = 0;
        while (n_start < 4 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (xif.xfer_start === 1'b1) n_start++;
        end
        n_cmp++; if (n_start !== 4) begin n_bad++; $display("FAIL mid_frame_byte3_seen: got %0d want 4", n_start); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({att, xif.xfer_start, xif.xfer_byte, buttons0, buttons1, valid, frame_done, frame_port, err_timeout, err_id} !== RST_VEC) begin n_bad++; $display("FAIL mid_frame_reset: got %h want %h", {att, xif.xfer_start, xif.xfer_byte, buttons0, buttons1, valid, frame_done, frame_port, err_timeout, err_id}, RST_VEC); end
        rst_n = 1'b1;
        cyc = -1;
        t_att = -1; t_s = -1; a_low = 2'b11; guard = 0;
        while (t_s < 0 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (t_att < 0 && att !== 2'b11) begin t_att = cyc; a_low = att; end
            if (xif.xfer_start === 1'b1) t_s = cyc;
        end
        n_cmp++; if (t_att !== BOOT || a_low !== 2'b10) begin n_bad++; $display("FAIL reboot_att_fall: got %0d/%b want %0d/10", t_att, a_low, BOOT); end
        n_cmp++; if (t_s !== BOOT + SET) begin n_bad++; $display("FAIL reboot_first_start: got %0d want %0d", t_s, BOOT + SET); end
        n_cmp++; if (buttons1 !== 16'hFFFF) begin n_bad++; $display("FAIL reboot_no_partial_word: got %h want FFFF", buttons1); end
    endtask

    initial begin
        test_reset();
        test_boot_good_frame();
        test_second_port();
        test_timeout();
        test_bad_id();
        test_early_ack();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
